// File: rtl/prbs_sync_checker.sv
// Self-synchronising PRBS checker: seeds a local LFSR from the received stream, then predicts and flags every bit.
// Latency: outputs registered, valid the cycle after the sampled bit. Backpressure: none, in_valid only qualifies input.
// Optional build macro PRBS_CHK_BITCNT_EN adds a saturating count of checked bits (bit_cnt).
module prbs_sync_checker #(
    parameter int unsigned WIDTH     = 8,
    parameter logic [31:0] TAPS      = 32'hB8,
    parameter int unsigned WINDOW    = 64,
    parameter int unsigned ERR_LIMIT = 4,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in,
    input  logic             in_valid,
    input  logic             clr,
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt
`ifdef PRBS_CHK_BITCNT_EN
    ,
    output logic [31:0]      bit_cnt
`endif
);

    localparam int unsigned SC_W = $clog2(WIDTH + 1);
    localparam int unsigned WC_W = $clog2(WINDOW + 1);
    localparam int unsigned EC_W = $clog2(ERR_LIMIT + 1);

    localparam logic [WIDTH-1:0] TAP_MASK  = TAPS[WIDTH-1:0];
    localparam logic [SC_W-1:0]  SEED_LAST = SC_W'(WIDTH - 1);
    localparam logic [WC_W-1:0]  WIN_LAST  = WC_W'(WINDOW - 1);
    localparam logic [EC_W-1:0]  ERR_LAST  = EC_W'(ERR_LIMIT - 1);

    typedef enum logic {
        SEED  = 1'b0,
        CHECK = 1'b1
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   h_q;
    logic [SC_W-1:0]    seed_cnt_q;
    logic [WC_W-1:0]    win_cnt_q;
    logic [EC_W-1:0]    win_err_q;
    logic               locked_q;
    logic               err_q;
    logic [CNT_W-1:0]   err_cnt_q;
    logic [CNT_W-1:0]   err_cnt_d;

    logic               pred;
    logic               mismatch;
    logic               check_vld;
    logic [WIDTH-1:0]   h_seed;
    logic [WIDTH-1:0]   h_pred;

    assign pred      = ^(h_q & TAP_MASK);
    assign mismatch  = in ^ pred;
    assign check_vld = in_valid && (state_q == CHECK);
    assign h_seed    = {h_q[WIDTH-2:0], in};
    // Shifting the prediction rather than the received bit keeps one line error from cascading.
    assign h_pred    = {h_q[WIDTH-2:0], pred};

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (clr) begin
            err_cnt_d = '0;
        end else if (check_vld && mismatch && (err_cnt_q != {CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= SEED;
            h_q        <= '0;
            seed_cnt_q <= '0;
            win_cnt_q  <= '0;
            win_err_q  <= '0;
            locked_q   <= 1'b0;
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            err_q     <= check_vld && mismatch;
            err_cnt_q <= err_cnt_d;
            if (in_valid) begin
                case (state_q)
                    SEED: begin
                        h_q <= h_seed;
                        if (seed_cnt_q == SEED_LAST) begin
                            seed_cnt_q <= '0;
                            // An all-zero history is the LFSR lockup state; keep seeding.
                            if (h_seed != '0) begin
                                state_q   <= CHECK;
                                locked_q  <= 1'b1;
                                win_cnt_q <= '0;
                                win_err_q <= '0;
                            end
                        end else begin
                            seed_cnt_q <= seed_cnt_q + SC_W'(1);
                        end
                    end
                    CHECK: begin
                        h_q <= h_pred;
                        if (mismatch && (win_err_q == ERR_LAST)) begin
                            state_q    <= SEED;
                            locked_q   <= 1'b0;
                            seed_cnt_q <= '0;
                            win_cnt_q  <= '0;
                            win_err_q  <= '0;
                        end else if (win_cnt_q == WIN_LAST) begin
                            win_cnt_q <= '0;
                            win_err_q <= '0;
                        end else begin
                            win_cnt_q <= win_cnt_q + WC_W'(1);
                            win_err_q <= win_err_q + EC_W'(mismatch);
                        end
                    end
                    default: state_q <= SEED;
                endcase
            end
        end
    end

    assign locked  = locked_q;
    assign err     = err_q;
    assign err_cnt = err_cnt_q;

`ifdef PRBS_CHK_BITCNT_EN
    logic [31:0] bit_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q <= '0;
        end else if (clr) begin
            bit_cnt_q <= '0;
        end else if (check_vld && (bit_cnt_q != 32'hFFFF_FFFF)) begin
            bit_cnt_q <= bit_cnt_q + 32'd1;
        end
    end

    assign bit_cnt = bit_cnt_q;
`endif

endmodule

// File: tb/tb_prbs_sync_checker.sv
// Bench for prbs_sync_checker: reference PRBS source, per-bit expectations queued at drive time and compared after the edge.
module tb_prbs_sync_checker;

    localparam int        CNT_W = 16;
    localparam logic [7:0] TAPS = 8'hB8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             din;
    logic             din_vld;
    logic             clr;
    logic             locked;
    logic             err;
    logic [CNT_W-1:0] err_cnt;
`ifdef PRBS_CHK_BITCNT_EN
    logic [31:0]      bit_cnt;
`endif

    typedef struct packed {
        logic e_err;
        logic e_lock;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] gen_q;

    always #5 clk = ~clk;

    prbs_sync_checker #(
        .WIDTH    (8),
        .TAPS     (32'hB8),
        .WINDOW   (64),
        .ERR_LIMIT(4),
        .CNT_W    (CNT_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in      (din),
        .in_valid(din_vld),
        .clr     (clr),
        .locked  (locked),
        .err     (err),
        .err_cnt (err_cnt)
`ifdef PRBS_CHK_BITCNT_EN
        ,
        .bit_cnt (bit_cnt)
`endif
    );

    task automatic gen_bit(output logic b);
        b     = ^(gen_q & TAPS);
        gen_q = {gen_q[6:0], b};
    endtask

    task automatic drive_bit(input logic d, input logic v, input logic c,
                             input logic e_err, input logic e_lock);
        @(negedge clk);
        din     = d;
        din_vld = v;
        clr     = c;
        sb.push_back('{e_err: e_err, e_lock: e_lock});
        @(posedge clk);
        #1;
        din_vld = 1'b0;
        clr     = 1'b0;
    endtask

    task automatic do_reset();
        din_vld = 1'b0;
        clr     = 1'b0;
        rst_n   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        din     = 1'b0;
        din_vld = 1'b0;
        clr     = 1'b0;
        gen_q   = 8'h01;
        #12;
        checks += 3;
        if (locked !== 1'b0) begin errors++; $display("FAIL reset locked: got %b want 0", locked); end
        if (err !== 1'b0) begin errors++; $display("FAIL reset err: got %b want 0", err); end
        if (err_cnt !== '0) begin errors++; $display("FAIL reset err_cnt: got %0d want 0", err_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_clean_lock();
        logic b;
        exp_t ex;
        for (int i = 0; i < 300; i++) begin
            gen_bit(b);
            drive_bit(b, 1'b1, 1'b0, 1'b0, i >= 7);
            ex = sb.pop_front();
            checks++;
            if (err !== ex.e_err || locked !== ex.e_lock) begin
                errors++;
                $display("FAIL clean bit %0d: err=%b locked=%b want err=%b locked=%b", i, err, locked, ex.e_err, ex.e_lock);
            end
        end
        checks++;
        if (err_cnt !== 16'd0) begin errors++; $display("FAIL clean err_cnt: got %0d want 0", err_cnt); end
    endtask

    task automatic test_single_flip();
        logic b, f;
        exp_t ex;
        for (int i = 0; i < 64; i++) begin
            gen_bit(b);
            f = (i == 39);
            drive_bit(b ^ f, 1'b1, 1'b0, f, 1'b1);
            ex = sb.pop_front();
            checks++;
            if (err !== ex.e_err || locked !== ex.e_lock) begin
                errors++;
                $display("FAIL single bit %0d: err=%b locked=%b want err=%b locked=%b", i, err, locked, ex.e_err, ex.e_lock);
            end
        end
        checks++;
        if (err_cnt !== 16'd1) begin errors++; $display("FAIL single err_cnt: got %0d want 1", err_cnt); end
    endtask

    task automatic test_burst_loss();
        logic b, f, l;
        int   j;
        exp_t ex;
        do_reset();
        for (int i = 0; i < 48; i++) begin
            gen_bit(b);
            j = i - 8;
            f = (i >= 8) && (j == 2 || j == 5 || j == 9 || j == 12);
            l = (i >= 7) && (j < 12 || j >= 20);
            drive_bit(b ^ f, 1'b1, 1'b0, f, l);
            ex = sb.pop_front();
            checks++;
            if (err !== ex.e_err || locked !== ex.e_lock) begin
                errors++;
                $display("FAIL burst bit %0d: err=%b locked=%b want err=%b locked=%b", i, err, locked, ex.e_err, ex.e_lock);
            end
        end
        checks++;
        if (err_cnt !== 16'd4) begin errors++; $display("FAIL burst err_cnt: got %0d want 4", err_cnt); end
    endtask

    task automatic test_zero_stream();
        logic b;
        exp_t ex;
        do_reset();
        for (int i = 0; i < 48; i++) begin
            if (i < 40) b = 1'b0;
            else gen_bit(b);
            drive_bit(b, 1'b1, 1'b0, 1'b0, i >= 47);
            ex = sb.pop_front();
            checks++;
            if (err !== ex.e_err || locked !== ex.e_lock) begin
                errors++;
                $display("FAIL zeros bit %0d: err=%b locked=%b want err=%b locked=%b", i, err, locked, ex.e_err, ex.e_lock);
            end
        end
    endtask

    task automatic test_random_valid_clr();
        logic b, v;
        int   nv;
        exp_t ex;
        do_reset();
        nv = 0;
        for (int c = 0; c < 400 && nv < 40; c++) begin
            v = 1'($urandom_range(0, 1));
            if (v) begin
                gen_bit(b);
                nv++;
            end else begin
                b = 1'($urandom_range(0, 1));
            end
            drive_bit(b, v, 1'b0, 1'b0, nv >= 8);
            ex = sb.pop_front();
            checks++;
            if (err !== ex.e_err || locked !== ex.e_lock) begin
                errors++;
                $display("FAIL gapped cycle %0d: err=%b locked=%b want err=%b locked=%b", c, err, locked, ex.e_err, ex.e_lock);
            end
        end
        gen_bit(b);
        drive_bit(~b, 1'b1, 1'b0, 1'b1, 1'b1);
        ex = sb.pop_front();
        checks += 2;
        if (err !== ex.e_err || locked !== ex.e_lock) begin
            errors++;
            $display("FAIL gapped flip: err=%b locked=%b want err=%b locked=%b", err, locked, ex.e_err, ex.e_lock);
        end
        if (err_cnt !== 16'd1) begin errors++; $display("FAIL gapped err_cnt: got %0d want 1", err_cnt); end
        gen_bit(b);
        drive_bit(~b, 1'b1, 1'b1, 1'b1, 1'b1);
        ex = sb.pop_front();
        checks += 2;
        if (err !== ex.e_err || locked !== ex.e_lock) begin
            errors++;
            $display("FAIL clr flip: err=%b locked=%b want err=%b locked=%b", err, locked, ex.e_err, ex.e_lock);
        end
        if (err_cnt !== 16'd0) begin errors++; $display("FAIL clr err_cnt: got %0d want 0", err_cnt); end
        drive_bit(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, 1'b1);
        ex = sb.pop_front();
        checks++;
        if (err !== ex.e_err || locked !== ex.e_lock) begin
            errors++;
            $display("FAIL idle after clr: err=%b locked=%b want err=%b locked=%b", err, locked, ex.e_err, ex.e_lock);
        end
    endtask

    task automatic test_async_reset();
        logic b;
        exp_t ex;
        gen_bit(b);
        drive_bit(~b, 1'b1, 1'b0, 1'b1, 1'b1);
        ex = sb.pop_front();
        checks += 2;
        if (err !== ex.e_err || locked !== ex.e_lock) begin
            errors++;
            $display("FAIL pre-reset flip: err=%b locked=%b want err=%b locked=%b", err, locked, ex.e_err, ex.e_lock);
        end
        if (err_cnt !== 16'd1) begin errors++; $display("FAIL pre-reset err_cnt: got %0d want 1", err_cnt); end
        #1 rst_n = 1'b0;
        #1;
        checks += 3;
        if (locked !== 1'b0) begin errors++; $display("FAIL async locked: got %b want 0", locked); end
        if (err !== 1'b0) begin errors++; $display("FAIL async err: got %b want 0", err); end
        if (err_cnt !== '0) begin errors++; $display("FAIL async err_cnt: got %0d want 0", err_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            gen_bit(b);
            drive_bit(b, 1'b1, 1'b0, 1'b0, i >= 7);
            ex = sb.pop_front();
            checks++;
            if (err !== ex.e_err || locked !== ex.e_lock) begin
                errors++;
                $display("FAIL relock bit %0d: err=%b locked=%b want err=%b locked=%b", i, err, locked, ex.e_err, ex.e_lock);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_lock();
        test_single_flip();
        test_burst_loss();
        test_zero_stream();
        test_random_valid_clr();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
